seq_divider: RTL and testbench



---
 rtl/seq_divider.sv | 184 ++++++++++++++++++
 tb/tb_seq_divider.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// ----------------------------------------------------------------------------
// seq_divider
//
// Multicycle restoring divider for MIPS DIV / DIVU. Operands are captured on
// an accepted start, the magnitude quotient is developed one bit per cycle
// (MSB first), and the signs are applied in a final fix-up cycle before the
// results are presented on hi (remainder) and lo (quotient).
//
// State table
//    state | meaning
//    IDLE  | waiting for start; divide-by-zero is reported from here
//    CALC  | one restoring step per cycle, WIDTH steps total
//    FIX   | apply quotient/remainder signs, load hi/lo, pulse done
//
// Ports
//    clk        in   system clock, rising edge
//    reset      in   asynchronous, active-low; clears all state
//    start      in   one-cycle request, sampled only in IDLE
//    is_signed  in   1 = DIV (two's complement), 0 = DIVU
//    dividend   in   rs operand, sampled with start
//    divisor    in   rt operand, sampled with start
//    busy       out  high from the cycle after an accepted start until done
//    done       out  one-cycle pulse, results valid or div-by-zero reported
//    div_zero   out  high together with done when the divisor was 0
//    hi         out  remainder, held until the next successful division
//    lo         out  quotient, held until the next successful division
// ----------------------------------------------------------------------------
module seq_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   // dvd_q starts as the dividend magnitude; each step shifts one dividend bit
   // out of the top and one quotient bit into the bottom, so after WIDTH steps
   // it holds the magnitude quotient.
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             q_neg_q, q_neg_d;
   logic             r_neg_q, r_neg_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             div_zero_q, div_zero_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;

   logic [WIDTH-1:0] dividend_mag;
   logic [WIDTH-1:0] divisor_mag;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;

   // 0x80000000 negates to itself, which is exactly the unsigned magnitude.
   assign dividend_mag = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
   assign divisor_mag  = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

   // The remainder is always below the divisor, so the shifted value fits in
   // WIDTH+1 bits and a non-negative trial always fits back into WIDTH bits.
   assign shifted = {rem_q, dvd_q[WIDTH-1]};
   assign trial   = shifted - {1'b0, dvs_q};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         dvd_q      <= '0;
         dvs_q      <= '0;
         rem_q      <= '0;
         cnt_q      <= '0;
         q_neg_q    <= 1'b0;
         r_neg_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
      end else begin
         state_q    <= state_d;
         dvd_q      <= dvd_d;
         dvs_q      <= dvs_d;
         rem_q      <= rem_d;
         cnt_q      <= cnt_d;
         q_neg_q    <= q_neg_d;
         r_neg_q    <= r_neg_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         div_zero_q <= div_zero_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      dvd_d      = dvd_q;
      dvs_d      = dvs_q;
      rem_d      = rem_q;
      cnt_d      = cnt_q;
      q_neg_d    = q_neg_q;
      r_neg_d    = r_neg_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      div_zero_d = 1'b0;
      hi_d       = hi_q;
      lo_d       = lo_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (divisor == '0) begin
                  // Report and stay put; hi/lo keep the previous result.
                  done_d     = 1'b1;
                  div_zero_d = 1'b1;
               end else begin
                  dvd_d   = dividend_mag;
                  dvs_d   = divisor_mag;
                  q_neg_d = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                  r_neg_d = is_signed & dividend[WIDTH-1];
                  rem_d   = '0;
                  cnt_d   = '0;
                  busy_d  = 1'b1;
                  state_d = CALC;
               end
            end
         end

         CALC: begin
            if (!trial[WIDTH]) begin
               rem_d = trial[WIDTH-1:0];
               dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
            end else begin
               rem_d = shifted[WIDTH-1:0];
               dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST_STEP) begin
               state_d = FIX;
            end
         end

         FIX: begin
            // Truncating division: quotient sign from both operands,
            // remainder sign from the dividend. Negation wraps mod 2^WIDTH.
            lo_d    = q_neg_q ? -dvd_q : dvd_q;
            hi_d    = r_neg_q ? -rem_q : rem_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign div_zero = div_zero_q;
   assign hi       = hi_q;
   assign lo       = lo_q;

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

   logic        clk;
   logic        reset;
   logic        start;
   logic        is_signed;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic        div_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_cmp;
   int n_bad;

   seq_divider #(.WIDTH(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .is_signed (is_signed),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .div_zero  (div_zero),
      .hi        (hi),
      .lo        (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Issues one division at a negedge and follows it to done. Timeline seen at
   // negedges: #1 is right after the accepting edge E0; done after E33 is #34.
   // Optionally pulses a foreign start mid-CALC, which must be ignored.
   task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] elo,
                         input logic [31:0] ehi, input logic ezero, input bit inject);
      int n;
      int busy_cnt;
      @(negedge clk);
      start     = 1'b1;
      is_signed = sgn;
      dividend  = a;
      divisor   = b;
      @(negedge clk);
      start    = 1'b0;
      n        = 1;
      busy_cnt = 0;
      while (!done && n < 100) begin
         if (busy) busy_cnt++;
         if (inject && n == 5) begin
            start     = 1'b1;
            is_signed = 1'b0;
            dividend  = 32'd1;
            divisor   = 32'd1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      check_eq({tag, "_done"},     {31'd0, done}, 32'd1);
      check_eq({tag, "_latency"},  n, ezero ? 32'd1 : 32'd34);
      check_eq({tag, "_busycyc"},  busy_cnt, ezero ? 32'd0 : 32'd33);
      check_eq({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
      check_eq({tag, "_divzero"},  {31'd0, div_zero}, {31'd0, ezero});
      check_eq({tag, "_lo"},       lo, elo);
      check_eq({tag, "_hi"},       hi, ehi);
      @(negedge clk);
      check_eq({tag, "_done_pulse"},    {31'd0, done}, 32'd0);
      check_eq({tag, "_divzero_pulse"}, {31'd0, div_zero}, 32'd0);
      check_eq({tag, "_lo_held"},       lo, elo);
   endtask

   initial begin
      int done_seen;
      n_cmp     = 0;
      n_bad     = 0;
      reset     = 1'b0;
      start     = 1'b0;
      is_signed = 1'b0;
      dividend  = '0;
      divisor   = '0;

      repeat (3) @(negedge clk);
      check_eq("rst_busy",     {31'd0, busy}, 32'd0);
      check_eq("rst_done",     {31'd0, done}, 32'd0);
      check_eq("rst_divzero",  {31'd0, div_zero}, 32'd0);
      check_eq("rst_hi",       hi, 32'd0);
      check_eq("rst_lo",       lo, 32'd0);
      reset = 1'b1;
      @(negedge clk);

      do_div("s7d2",     1'b1, 32'd7,        32'd2,        32'd3,        32'd1,        1'b0, 1'b0);
      do_div("sm7d2",    1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0);
      do_div("s7dm2",    1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0, 1'b0);
      do_div("uffd2",    1'b0, 32'hFFFFFFFF, 32'd2,        32'h7FFFFFFF, 32'd1,        1'b0, 1'b0);
      do_div("sffd2",    1'b1, 32'hFFFFFFFF, 32'd2,        32'd0,        32'hFFFFFFFF, 1'b0, 1'b0);
      do_div("pre5d3",   1'b0, 32'd5,        32'd3,        32'd1,        32'd2,        1'b0, 1'b0);
      do_div("u9d0",     1'b0, 32'd9,        32'd0,        32'd1,        32'd2,        1'b1, 1'b0);
      do_div("sminm1",   1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 1'b0);
      do_div("umaxdmax", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1'b0);

      // Reset at step 10 of 100/7: everything clears, no done afterwards.
      @(negedge clk);
      start     = 1'b1;
      is_signed = 1'b1;
      dividend  = 32'd100;
      divisor   = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      check_eq("mid_busy_before_rst", {31'd0, busy}, 32'd1);
      #2 reset = 1'b0;
      #1;
      check_eq("arst_busy",    {31'd0, busy}, 32'd0);
      check_eq("arst_done",    {31'd0, done}, 32'd0);
      check_eq("arst_divzero", {31'd0, div_zero}, 32'd0);
      check_eq("arst_hi",      hi, 32'd0);
      check_eq("arst_lo",      lo, 32'd0);
      @(negedge clk);
      reset     = 1'b1;
      done_seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done || busy) done_seen++;
      end
      check_eq("arst_no_done", done_seen, 32'd0);

      do_div("s100d7_inj", 1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
